// File: rtl/cmsdk_apb4_eg_master_if.sv
// Bundle of command, response and APB4 signals for the example APB4 master.
// The master modport is the initiator side; the slave modport is the far side.
interface cmsdk_apb4_eg_master_if #(
    parameter int ADDRWIDTH = 12
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_write;
    logic [ADDRWIDTH-1:0] cmd_addr;
    logic [31:0]          cmd_wdata;
    logic [3:0]           cmd_strb;
    logic [2:0]           cmd_prot;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [31:0]          rsp_rdata;
    logic                 rsp_err;
    logic                 rsp_timeout;

    logic                 PSEL;
    logic                 PENABLE;
    logic [ADDRWIDTH-1:0] PADDR;
    logic                 PWRITE;
    logic [31:0]          PWDATA;
    logic [3:0]           PSTRB;
    logic [2:0]           PPROT;
    logic [31:0]          PRDATA;
    logic                 PREADY;
    logic                 PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/cmsdk_apb4_eg_master.sv
// APB4 initiator: one command at a time through SETUP/ACCESS, with a
// wait-state watchdog so an unresponsive slave cannot hang the master.
module cmsdk_apb4_eg_master #(
    parameter int ADDRWIDTH = 12,
    parameter int TIMEOUT   = 256
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    cmsdk_apb4_eg_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam bit          WDOG_EN   = (TIMEOUT != 0);
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

    state_t               state_q, state_d;
    logic [15:0]          wdog_q, wdog_d;
    logic                 psel_q, penable_q, rsp_valid_q;
    logic [ADDRWIDTH-1:0] paddr_q, paddr_d;
    logic                 pwrite_q, pwrite_d;
    logic [31:0]          pwdata_q, pwdata_d;
    logic [3:0]           pstrb_q, pstrb_d;
    logic [2:0]           pprot_q, pprot_d;
    logic [31:0]          rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 rsp_timeout_q, rsp_timeout_d;
    logic                 timeout_hit;

    // The last allowed wait cycle abandons the transfer; PREADY in that cycle wins.
    assign timeout_hit = WDOG_EN && (state_q == ACCESS) && !bus.PREADY
                         && (wdog_q == WDOG_LAST);

    always_comb begin
        state_d       = state_q;
        wdog_d        = 16'd0;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        pprot_d       = pprot_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    paddr_d  = bus.cmd_addr;
                    pwrite_d = bus.cmd_write;
                    pwdata_d = bus.cmd_wdata;
                    pstrb_d  = bus.cmd_write ? bus.cmd_strb : 4'b0000;
                    pprot_d  = bus.cmd_prot;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    rsp_rdata_d   = pwrite_q ? 32'd0 : bus.PRDATA;
                    rsp_err_d     = bus.PSLVERR;
                    rsp_timeout_d = 1'b0;
                    state_d       = RESP;
                end else if (timeout_hit) begin
                    rsp_rdata_d   = 32'd0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = RESP;
                end else begin
                    wdog_d = wdog_q + 16'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus strobes are decoded from the next state so they come straight from flops.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q       <= IDLE;
            wdog_q        <= 16'd0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= 32'd0;
            pstrb_q       <= 4'd0;
            pprot_q       <= 3'd0;
            rsp_rdata_q   <= 32'd0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wdog_q        <= wdog_d;
            psel_q        <= (state_d == SETUP) || (state_d == ACCESS);
            penable_q     <= (state_d == ACCESS);
            rsp_valid_q   <= (state_d == RESP);
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            pprot_q       <= pprot_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign bus.cmd_ready   = (state_q == IDLE);
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.PSEL        = psel_q;
    assign bus.PENABLE     = penable_q;
    assign bus.PADDR       = paddr_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PWDATA      = pwdata_q;
    assign bus.PSTRB       = pstrb_q;
    assign bus.PPROT       = pprot_q;
endmodule

// File: tb/tb_cmsdk_apb4_eg_master.sv
// Directed bench for the APB4 example master: a table of transfers with a
// scripted slave, plus reset-state and mid-transfer reset sequences.
module tb_cmsdk_apb4_eg_master;
    localparam int AW = 12;
    localparam int TO = 4;
    localparam int NV = 9;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    strb;
        logic [2:0]    prot;
        int            waits;      // PREADY low cycles before it rises
        logic [31:0]   prdata;
        logic          slverr;
        logic          pulse_err;  // drive PSLVERR=1 on wait cycles
        int            bp;         // rsp_ready low cycles
        int            exp_acc;    // ACCESS cycles expected
        logic [31:0]   exp_rdata;
        logic          exp_err;
        logic          exp_to;
    } vec_t;

    logic PCLK = 1'b0;
    logic PRESET;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs [NV];

    cmsdk_apb4_eg_master_if #(.ADDRWIDTH(AW)) bus ();

    cmsdk_apb4_eg_master #(.ADDRWIDTH(AW), .TIMEOUT(TO)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_cmd(input vec_t v);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = v.wr;
        bus.cmd_addr  = v.addr;
        bus.cmd_wdata = v.wdata;
        bus.cmd_strb  = v.strb;
        bus.cmd_prot  = v.prot;
    endtask

    task automatic check_apb(input string tag, input vec_t v, input logic en);
        check({tag, " PSEL"},    bus.PSEL, 1'b1);
        check({tag, " PENABLE"}, bus.PENABLE, en);
        check({tag, " PADDR"},   bus.PADDR, v.addr);
        check({tag, " PWRITE"},  bus.PWRITE, v.wr);
        check({tag, " PWDATA"},  bus.PWDATA, v.wdata);
        check({tag, " PSTRB"},   bus.PSTRB, v.wr ? v.strb : 4'h0);
        check({tag, " PPROT"},   bus.PPROT, v.prot);
        check({tag, " cmd_ready"}, bus.cmd_ready, 1'b0);
    endtask

    task automatic run_xfer(input int idx, input vec_t v);
        string tag;
        int    k;
        logic  rdy;
        tag = $sformatf("v%0d", idx);
        // Idle cycle: command presented here is accepted at the next edge.
        check({tag, " idle cmd_ready"}, bus.cmd_ready, 1'b1);
        check({tag, " idle PSEL"}, bus.PSEL, 1'b0);
        drive_cmd(v);
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        bus.PRDATA  = 32'hDEAD_BEEF;
        @(negedge PCLK);
        bus.cmd_valid = 1'b0;
        check_apb({tag, " setup"}, v, 1'b0);
        @(negedge PCLK);
        k = 0;
        while (bus.PSEL === 1'b1 && k < 20) begin
            check_apb($sformatf("%s acc%0d", tag, k), v, 1'b1);
            rdy = (k == v.waits);
            bus.PREADY  = rdy;
            bus.PRDATA  = rdy ? v.prdata : 32'hDEAD_BEEF;
            bus.PSLVERR = rdy ? v.slverr : v.pulse_err;
            k++;
            @(negedge PCLK);
        end
        check({tag, " access cycles"}, k, v.exp_acc);
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        for (int b = 0; b <= v.bp; b++) begin
            check($sformatf("%s rsp%0d rsp_valid", tag, b), bus.rsp_valid, 1'b1);
            check($sformatf("%s rsp%0d rsp_rdata", tag, b), bus.rsp_rdata, v.exp_rdata);
            check($sformatf("%s rsp%0d rsp_err", tag, b), bus.rsp_err, v.exp_err);
            check($sformatf("%s rsp%0d rsp_timeout", tag, b), bus.rsp_timeout, v.exp_to);
            check($sformatf("%s rsp%0d PSEL", tag, b), bus.PSEL, 1'b0);
            check($sformatf("%s rsp%0d PENABLE", tag, b), bus.PENABLE, 1'b0);
            check($sformatf("%s rsp%0d cmd_ready", tag, b), bus.cmd_ready, 1'b0);
            bus.cmd_valid = (b < v.bp);
            bus.rsp_ready = (b == v.bp);
            @(negedge PCLK);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        check({tag, " done rsp_valid"}, bus.rsp_valid, 1'b0);
        check({tag, " done cmd_ready"}, bus.cmd_ready, 1'b1);
        check({tag, " done PSEL"}, bus.PSEL, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vec_t rv;
        //            wr   addr     wdata         strb  prot  wt  prdata        err  pls  bp acc exp_rdata     e    to
        vecs[0] = '{1'b1, 12'h010, 32'hA5A5_5A5A, 4'hF, 3'd0, 0,  32'hFFFF_FFFF, 1'b0, 1'b0, 0, 1, 32'h0,         1'b0, 1'b0};
        vecs[1] = '{1'b0, 12'h020, 32'h1111_1111, 4'hF, 3'd2, 3,  32'h1234_5678, 1'b0, 1'b0, 0, 4, 32'h1234_5678, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 12'h030, 32'hCAFE_F00D, 4'h3, 3'd1, 0,  32'h0,         1'b1, 1'b0, 0, 1, 32'h0,         1'b1, 1'b0};
        vecs[3] = '{1'b0, 12'h044, 32'h0,         4'h0, 3'd4, 2,  32'h0BAD_F00D, 1'b0, 1'b1, 0, 3, 32'h0BAD_F00D, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 12'hFFC, 32'h0,         4'h0, 3'd7, 99, 32'h7777_7777, 1'b0, 1'b0, 0, 4, 32'h0,         1'b1, 1'b1};
        vecs[5] = '{1'b1, 12'h100, 32'h0F0F_0F0F, 4'h5, 3'd3, 3,  32'h0,         1'b0, 1'b0, 0, 4, 32'h0,         1'b0, 1'b0};
        vecs[6] = '{1'b0, 12'h200, 32'h0,         4'hA, 3'd5, 1,  32'h55AA_55AA, 1'b0, 1'b0, 5, 2, 32'h55AA_55AA, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 12'h3F0, 32'h0,         4'hF, 3'd6, 3,  32'h8765_4321, 1'b1, 1'b0, 0, 4, 32'h8765_4321, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 12'h0AC, 32'h1357_9BDF, 4'hC, 3'd0, 99, 32'h2468_ACE0, 1'b0, 1'b1, 0, 4, 32'h0,         1'b1, 1'b1};

        PRESET        = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = 32'd0;
        bus.cmd_strb  = 4'd0;
        bus.cmd_prot  = 3'd0;
        bus.rsp_ready = 1'b0;
        bus.PRDATA    = 32'd0;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;
        repeat (3) @(negedge PCLK);

        check("reset cmd_ready", bus.cmd_ready, 1'b1);
        check("reset PSEL", bus.PSEL, 1'b0);
        check("reset PENABLE", bus.PENABLE, 1'b0);
        check("reset rsp_valid", bus.rsp_valid, 1'b0);
        check("reset PADDR", bus.PADDR, 32'h0);
        check("reset PWDATA", bus.PWDATA, 32'h0);
        check("reset PSTRB", bus.PSTRB, 32'h0);
        check("reset rsp_err", bus.rsp_err, 1'b0);
        check("reset rsp_timeout", bus.rsp_timeout, 1'b0);
        PRESET = 1'b0;
        @(negedge PCLK);

        for (int i = 0; i < NV; i++) begin
            run_xfer(i, vecs[i]);
        end

        // Reset while the slave is stalling in ACCESS.
        rv = '{1'b1, 12'h5A0, 32'hFEED_FACE, 4'hF, 3'd1, 99, 32'h0, 1'b0, 1'b0, 0, 0, 32'h0, 1'b0, 1'b0};
        drive_cmd(rv);
        @(negedge PCLK);
        bus.cmd_valid = 1'b0;
        check("rst seq setup PSEL", bus.PSEL, 1'b1);
        @(negedge PCLK);
        check("rst seq access PENABLE", bus.PENABLE, 1'b1);
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        check("rst seq PSEL", bus.PSEL, 1'b0);
        check("rst seq PENABLE", bus.PENABLE, 1'b0);
        check("rst seq rsp_valid", bus.rsp_valid, 1'b0);
        check("rst seq cmd_ready", bus.cmd_ready, 1'b1);
        check("rst seq PADDR", bus.PADDR, 32'h0);
        @(negedge PCLK);
        check("rst seq no rsp", bus.rsp_valid, 1'b0);
        run_xfer(100, vecs[1]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cmsdk_apb4_eg_master.md
Name: cmsdk_apb4_eg_master

Overview:
APB4 initiator that turns a simple valid/ready command port into APB4 SETUP/ACCESS transfers, then returns read data and error status on a valid/ready response port. It is the bus-driving counterpart to the team's APB4 example slave, and is used by test masters, DMA-lite engines and bridge front ends inside the M0 subsystem. One transfer is outstanding at a time, and a wait-state watchdog prevents a hung slave from locking the master.

Parameters:
ADDRWIDTH, 12, width of PADDR and cmd_addr.
TIMEOUT, 256, number of consecutive PREADY-low ACCESS cycles before the transfer is abandoned; 0 disables the watchdog; legal range 0..65535.

Ports:
PCLK  input  1  clock.
PRESET  input  1  synchronous reset, active-high.
cmd_valid  input  1  command request.
cmd_ready  output  1  command accepted when high together with cmd_valid.
cmd_write  input  1  1 = write, 0 = read.
cmd_addr  input  ADDRWIDTH  transfer address.
cmd_wdata  input  32  write data.
cmd_strb  input  4  write byte strobes.
cmd_prot  input  3  PPROT value.
rsp_valid  output  1  response available.
rsp_ready  input  1  response consumed.
rsp_rdata  output  32  read data; 0 for writes and timeouts.
rsp_err  output  1  PSLVERR captured, or timeout.
rsp_timeout  output  1  transfer abandoned by the watchdog.
PSEL  output  1  APB select.
PENABLE  output  1  APB enable.
PADDR  output  ADDRWIDTH  APB address.
PWRITE  output  1  APB direction.
PWDATA  output  32  APB write data.
PSTRB  output  4  APB strobes.
PPROT  output  3  APB protection.
PRDATA  input  32  APB read data.
PREADY  input  1  APB ready.
PSLVERR  input  1  APB error.

Behaviour:
- Clock and reset: the interface has one clock, PCLK; reset is synchronous and active-high on PRESET. Reset is sampled only on the PCLK rising edge.
- Register outputs: all outputs except cmd_ready are registered.
- Reset values: all outputs are 0, except cmd_ready, which is 1 because the state is IDLE. The state resets to IDLE and the watchdog counter to 0.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1 and PSEL=0.
  - On cmd_valid, latch addr, write, wdata, strb and prot into the APB output registers, then go to SETUP.
  - PSTRB is forced to 4'b0000 for reads.
- SETUP (exactly one cycle): PSEL=1, PENABLE=0, then go to ACCESS unconditionally.
- ACCESS:
  - PSEL=1 and PENABLE=1.
  - PADDR, PWRITE, PWDATA, PSTRB and PPROT stay stable from SETUP until the transfer ends.
  - On PREADY=1:
    - capture rsp_rdata = PRDATA for reads, or 0 for writes;
    - capture rsp_err = PSLVERR and rsp_timeout = 0;
    - go to RESP.
  - PSLVERR is ignored whenever PREADY=0.
- Watchdog:
  - The counter increments on each ACCESS cycle with PREADY=0 and clears on leaving ACCESS.
  - When TIMEOUT≠0 and the counter reaches TIMEOUT-1 with PREADY still 0, the transfer is abandoned: go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - PREADY=1 on the same cycle wins: a normal completion takes priority over the timeout.
- RESP:
  - rsp_valid=1, PSEL=0, PENABLE=0, cmd_ready=0.
  - rsp_rdata, rsp_err and rsp_timeout stay stable until rsp_ready.
  - On rsp_ready, rsp_valid goes to 0 and the state returns to IDLE.
- Latency: a command accepted at edge N gives:
  - SETUP in cycle N+1;
  - ACCESS in cycle N+2;
  - with zero wait states, rsp_valid=1 in cycle N+3.
- Throughput:
  - Back-to-back commands need one IDLE cycle between transfers, so the minimum is 4 cycles per transfer.
  - PSEL drops for at least 2 cycles between transfers.
- Mid-transfer reset: PRESET asserted during any state forces IDLE on the next edge. PSEL, PENABLE and rsp_valid drop immediately after that edge, and no response is produced.
- Out of scope: no pipelining of commands and no reordering.

Test Plan:
- Zero-wait write: cmd addr=0x010, wdata=0xA5A5_5A5A, strb=4'hF, PREADY tied 1 -> PSEL in cycles N+1..N+2, PENABLE in cycle N+2, PSTRB=4'hF; rsp_valid at N+3 with rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: slave returns PRDATA=0x1234_5678 on the 4th ACCESS cycle -> PADDR and control stable for 4 ACCESS cycles; PSTRB=0; rsp_rdata=0x1234_5678, rsp_err=0.
- Slave error: write with PSLVERR=1 and PREADY=1 -> rsp_err=1, rsp_timeout=0. Separately, PSLVERR=1 pulsed while PREADY=0 is ignored.
- Timeout: TIMEOUT=4, PREADY held 0 -> exactly 4 ACCESS cycles, then PSEL=0; rsp_err=1, rsp_timeout=1, rsp_rdata=0. Repeat with PREADY=1 on the 4th cycle -> normal completion.
- Response backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid and data stable, cmd_ready=0, no new SETUP. Then rsp_ready=1 -> IDLE and cmd_ready=1 on the next cycle.
- Reset mid-ACCESS: assert PRESET while in ACCESS -> after one edge PSEL=0, PENABLE=0, rsp_valid=0, cmd_ready=1. A following command completes normally.
